// File: rtl/demultiplexer_buffered_pkg.sv
// Shared definitions for the buffered 1-to-2 demultiplexer: select encodings
// and the pointer-width helper used by the per-output FIFOs.
package demultiplexer_buffered_pkg;

  localparam logic SEL_OPTION1 = 1'b0;
  localparam logic SEL_OPTION2 = 1'b1;

  // Ceiling log2, evaluated at elaboration time for pointer widths.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (remaining > 0) begin
        result    = result + 1;
        remaining = remaining >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO for one demultiplexer output. Fullness comes from
// registered state only, so a same-cycle pop never opens room for a push.
module demux_fifo
  import demultiplexer_buffered_pkg::*;
#(
  parameter int n     = 32,
  parameter int depth = 2
) (
  input  logic         clockInput,
  input  logic         resetInput,
  input  logic         pushInput,
  input  logic [n-1:0] dataInput,
  output logic         fullOutput,
  output logic         validOutput,
  output logic [n-1:0] dataOutput,
  input  logic         popInput
);

  localparam int AW = clog2(depth);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(depth);
  localparam logic [AW-1:0] PTR_STEP   = AW'(1);
  localparam logic [AW:0]   COUNT_STEP = (AW + 1)'(1);

  logic [n-1:0]  mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign fullOutput  = (count == COUNT_FULL);
  assign validOutput = (count != '0);
  assign dataOutput  = mem[rd_ptr];

  // Guard locally too, so the FIFO can never overflow or underflow.
  assign push = pushInput && !fullOutput;
  assign pop  = popInput && validOutput;

  always_ff @(posedge clockInput) begin
    if (!resetInput) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_STEP;
      if (pop)  rd_ptr <= rd_ptr + PTR_STEP;
      case ({push, pop})
        2'b10:   count <= count + COUNT_STEP;
        2'b01:   count <= count - COUNT_STEP;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; validOutput masks stale entries.
  always_ff @(posedge clockInput) begin
    if (push) mem[wr_ptr] <= dataInput;
  end

endmodule

// File: rtl/demultiplexer_buffered.sv
// 1-to-2 valid/ready demultiplexer: each beat is steered by selectionInput
// into one of two output FIFOs so a stalled consumer only blocks its own beats.
module demultiplexer_buffered
  import demultiplexer_buffered_pkg::*;
#(
  parameter int n     = 32,
  parameter int depth = 2
) (
  input  logic         clockInput,
  input  logic         resetInput,
  input  logic [n-1:0] dataInput,
  input  logic         selectionInput,
  input  logic         validInput,
  output logic         readyOutput,
  output logic [n-1:0] option1Output,
  output logic         option1ValidOutput,
  input  logic         option1ReadyInput,
  output logic [n-1:0] option2Output,
  output logic         option2ValidOutput,
  input  logic         option2ReadyInput
);

  logic full1;
  logic full2;
  logic accept;
  logic push1;
  logic push2;

  // Ready depends only on the select and registered fullness, never on validInput.
  assign readyOutput = (selectionInput == SEL_OPTION2) ? !full2 : !full1;
  assign accept      = validInput && readyOutput;
  assign push1       = accept && (selectionInput == SEL_OPTION1);
  assign push2       = accept && (selectionInput == SEL_OPTION2);

  demux_fifo #(.n(n), .depth(depth)) u_fifo1 (
    .clockInput  (clockInput),
    .resetInput  (resetInput),
    .pushInput   (push1),
    .dataInput   (dataInput),
    .fullOutput  (full1),
    .validOutput (option1ValidOutput),
    .dataOutput  (option1Output),
    .popInput    (option1ReadyInput)
  );

  demux_fifo #(.n(n), .depth(depth)) u_fifo2 (
    .clockInput  (clockInput),
    .resetInput  (resetInput),
    .pushInput   (push2),
    .dataInput   (dataInput),
    .fullOutput  (full2),
    .validOutput (option2ValidOutput),
    .dataOutput  (option2Output),
    .popInput    (option2ReadyInput)
  );

endmodule

// File: tb/tb_demultiplexer_buffered.sv
// Directed bench for demultiplexer_buffered: steering, back-pressure isolation,
// full-while-draining, pointer wrap-around and mid-operation reset.
module tb_demultiplexer_buffered;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        sel;
  logic        vin;
  logic        rdy;
  logic [31:0] o1;
  logic        v1;
  logic        r1;
  logic [31:0] o2;
  logic        v2;
  logic        r2;

  int checks;
  int failures;

  demultiplexer_buffered #(.n(32), .depth(2)) dut (
    .clockInput         (clk),
    .resetInput         (rst_n),
    .dataInput          (din),
    .selectionInput     (sel),
    .validInput         (vin),
    .readyOutput        (rdy),
    .option1Output      (o1),
    .option1ValidOutput (v1),
    .option1ReadyInput  (r1),
    .option2Output      (o2),
    .option2ValidOutput (v2),
    .option2ReadyInput  (r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int sent;
  int recv;
  int cyc;
  bit acc;
  bit pop;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0; din = '0; sel = 1'b0; vin = 1'b0; r1 = 1'b0; r2 = 1'b0;
    #1;
    step(); step();
    rst_n = 1'b1;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_ready", {31'b0, rdy}, 32'd1);
      chk("idle_v1", {31'b0, v1}, 32'd0);
      chk("idle_v2", {31'b0, v2}, 32'd0);
      step();
    end

    // Steering
    r1 = 1'b1; r2 = 1'b1;
    vin = 1'b1; sel = 1'b0; din = 32'hA5A5A5A5;
    #1 chk("steer_ready0", {31'b0, rdy}, 32'd1);
    step();
    sel = 1'b1; din = 32'h5A5A5A5A;
    #1;
    chk("steer_v1", {31'b0, v1}, 32'd1);
    chk("steer_o1", o1, 32'hA5A5A5A5);
    chk("steer_v2_idle", {31'b0, v2}, 32'd0);
    step();
    vin = 1'b0;
    #1;
    chk("steer_v1_gone", {31'b0, v1}, 32'd0);
    chk("steer_v2", {31'b0, v2}, 32'd1);
    chk("steer_o2", o2, 32'h5A5A5A5A);
    step();
    chk("steer_v2_gone", {31'b0, v2}, 32'd0);

    // Back-pressure isolation
    r1 = 1'b0; r2 = 1'b1;
    vin = 1'b1; sel = 1'b0; din = 32'h1;
    #1 chk("bp_ready1", {31'b0, rdy}, 32'd1);
    step();
    din = 32'h2;
    #1 chk("bp_ready2", {31'b0, rdy}, 32'd1);
    step();
    din = 32'h3;
    #1 chk("bp_ready_full", {31'b0, rdy}, 32'd0);
    step();
    #1;
    chk("bp_still_full", {31'b0, rdy}, 32'd0);
    chk("bp_head1", o1, 32'h1);
    sel = 1'b1; din = 32'h4;
    #1 chk("bp_ready_sel2", {31'b0, rdy}, 32'd1);
    step();
    sel = 1'b0; din = 32'h3; r1 = 1'b1;
    #1;
    chk("bp_v2", {31'b0, v2}, 32'd1);
    chk("bp_o2", o2, 32'h4);
    chk("bp_full_draining", {31'b0, rdy}, 32'd0);
    step();
    #1;
    chk("bp_drain_o1", o1, 32'h2);
    chk("bp_v2_gone", {31'b0, v2}, 32'd0);
    chk("bp_ready_room", {31'b0, rdy}, 32'd1);
    step();
    vin = 1'b0;
    #1;
    chk("bp_v1_last", {31'b0, v1}, 32'd1);
    chk("bp_o1_last", o1, 32'h3);
    step();
    chk("bp_empty", {31'b0, v1}, 32'd0);

    // Full with simultaneous pop
    r1 = 1'b0;
    vin = 1'b1; sel = 1'b0; din = 32'h10;
    step();
    din = 32'h11;
    step();
    r1 = 1'b1; din = 32'h12;
    #1;
    chk("fp_ready_low", {31'b0, rdy}, 32'd0);
    chk("fp_head0", o1, 32'h10);
    step();
    #1;
    chk("fp_ready_back", {31'b0, rdy}, 32'd1);
    chk("fp_head1", o1, 32'h11);
    step();
    vin = 1'b0;
    #1 chk("fp_head2", o1, 32'h12);
    step();
    chk("fp_empty", {31'b0, v1}, 32'd0);

    // Wrap-around through option2 with toggling ready
    r1 = 1'b0;
    sent = 0; recv = 0; cyc = 0;
    sel = 1'b1;
    while (recv < 20 && cyc < 200) begin
      r2  = (cyc % 2 == 0);
      vin = (sent < 20);
      din = sent;
      #1;
      acc = vin && rdy;
      pop = v2 && r2;
      if (pop) begin
        chk("wrap_order", o2, recv);
        recv++;
      end
      if (acc) sent++;
      step();
      cyc++;
    end
    vin = 1'b0;
    chk("wrap_count", recv, 32'd20);
    #1 chk("wrap_drained", {31'b0, v2}, 32'd0);

    // Reset mid-operation
    r1 = 1'b0; r2 = 1'b0;
    vin = 1'b1;
    sel = 1'b0; din = 32'hB1; step();
    din = 32'hB2; step();
    sel = 1'b1; din = 32'hC1; step();
    din = 32'hC2; step();
    vin = 1'b0;
    #1;
    chk("mr_v1_loaded", {31'b0, v1}, 32'd1);
    chk("mr_v2_loaded", {31'b0, v2}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sel = 1'b0;
    #1;
    chk("mr_v1_cleared", {31'b0, v1}, 32'd0);
    chk("mr_v2_cleared", {31'b0, v2}, 32'd0);
    chk("mr_ready", {31'b0, rdy}, 32'd1);
    vin = 1'b1; din = 32'hD1;
    step();
    vin = 1'b0;
    #1;
    chk("mr_new_head", o1, 32'hD1);
    chk("mr_v2_stays", {31'b0, v2}, 32'd0);
    r1 = 1'b1;
    step();
    chk("mr_no_stale", {31'b0, v1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
